// File: rtl/country_sensor_conditioner_pkg.sv
// Shared definitions for the country-road sensor conditioner: lamp codes seen on the
// controller feedback bus and the debounce FSM state type.
package country_sensor_conditioner_pkg;

  localparam logic [1:0] LAMP_RED    = 2'd0;
  localparam logic [1:0] LAMP_YELLOW = 2'd1;
  localparam logic [1:0] LAMP_GREEN  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ARMING    = 2'd1,
    ST_PRESENT   = 2'd2,
    ST_RELEASING = 2'd3
  } deb_state_e;

endpackage

// File: rtl/country_sensor_conditioner_sync_2ff.sv
// Two-flop synchroniser bringing the asynchronous loop-detector level into the clk domain.
module country_sensor_conditioner_sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/country_sensor_conditioner.sv
// Synchronises and debounces the country-road vehicle loop, counts arrivals and holds
// the car-waiting request x until the controller shows country GREEN.
module country_sensor_conditioner
  import country_sensor_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DEB_W           = 3,
  parameter int QUEUE_W         = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sensor_raw,
  input  logic [1:0]         cntry,
  output logic               x,
  output logic               present,
  output logic [QUEUE_W-1:0] car_cnt
);

  // The sample that leaves IDLE/PRESENT is the first of the DEBOUNCE_CYCLES run, so the
  // counter only has to cover the remaining samples after it.
  localparam logic [DEB_W-1:0]   DEB_LAST = DEB_W'((DEBOUNCE_CYCLES > 1) ? DEBOUNCE_CYCLES - 2 : 0);
  localparam logic [QUEUE_W-1:0] CNT_MAX  = '1;
  localparam bit                 DEB_ONE  = (DEBOUNCE_CYCLES == 1);

  logic               s;
  deb_state_e         state_q, state_d;
  logic [DEB_W-1:0]   deb_q, deb_d;
  logic [QUEUE_W-1:0] cnt_q, cnt_d;
  logic               present_q, present_d;
  logic               x_q;
  logic               arrival;

  country_sensor_conditioner_sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (sensor_raw),
    .q_o   (s)
  );

  always_comb begin
    state_d = state_q;
    deb_d   = deb_q;
    arrival = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (s) begin
          if (DEB_ONE) begin
            state_d = ST_PRESENT;
            arrival = 1'b1;
          end else begin
            state_d = ST_ARMING;
            deb_d   = '0;
          end
        end
      end
      ST_ARMING: begin
        if (!s) begin
          state_d = ST_IDLE;
        end else if (deb_q == DEB_LAST) begin
          state_d = ST_PRESENT;
          arrival = 1'b1;
        end else begin
          deb_d = deb_q + 1'b1;
        end
      end
      ST_PRESENT: begin
        if (!s) begin
          state_d = DEB_ONE ? ST_IDLE : ST_RELEASING;
          deb_d   = '0;
        end
      end
      ST_RELEASING: begin
        if (s) begin
          state_d = ST_PRESENT;
        end else if (deb_q == DEB_LAST) begin
          state_d = ST_IDLE;
        end else begin
          deb_d = deb_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    present_d = (state_d == ST_PRESENT) || (state_d == ST_RELEASING);

    // GREEN serves every waiting car, including one arriving on the same edge.
    if (cntry == LAMP_GREEN) begin
      cnt_d = '0;
    end else if (arrival && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      deb_q     <= '0;
      cnt_q     <= '0;
      present_q <= 1'b0;
      x_q       <= 1'b0;
    end else begin
      state_q   <= state_d;
      deb_q     <= deb_d;
      cnt_q     <= cnt_d;
      present_q <= present_d;
      x_q       <= (cnt_d != '0);
    end
  end

  assign x       = x_q;
  assign present = present_q;
  assign car_cnt = cnt_q;

endmodule

// File: tb/tb_country_sensor_conditioner.sv
// Directed and randomized checks of country_sensor_conditioner against a run-length
// reference model of the synchronise/debounce/count behaviour.
module tb_country_sensor_conditioner;
  import country_sensor_conditioner_pkg::*;

  localparam int D  = 4;
  localparam int QW = 4;
  localparam int CMAX = (1 << QW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          sensor_raw = 1'b0;
  logic [1:0]    cntry = 2'd0;
  logic          x;
  logic          present;
  logic [QW-1:0] car_cnt;

  int tests = 0;
  int fails = 0;

  // Reference model state: two-stage delay line, accepted level, run length, queue count.
  logic m_s1, m_s2, m_lvl;
  int   m_run, m_cnt;

  country_sensor_conditioner #(
    .DEBOUNCE_CYCLES (D),
    .DEB_W           (3),
    .QUEUE_W         (QW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sensor_raw (sensor_raw),
    .cntry      (cntry),
    .x          (x),
    .present    (present),
    .car_cnt    (car_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic [1:0] c, input logic rs);
    logic s, arr;
    if (rs) begin
      m_s1 = 0; m_s2 = 0; m_lvl = 0; m_run = 0; m_cnt = 0;
    end else begin
      s = m_s2; m_s2 = m_s1; m_s1 = r; arr = 0;
      if (s != m_lvl) begin
        m_run++;
        if (m_run == D) begin
          m_lvl = s; m_run = 0; arr = s;
        end
      end else begin
        m_run = 0;
      end
      if (c == LAMP_GREEN) m_cnt = 0;
      else if (arr && m_cnt < CMAX) m_cnt++;
    end
  endtask

  task automatic step(input logic r, input logic [1:0] c, input logic rs, input string tag);
    sensor_raw = r; cntry = c; reset = rs;
    @(posedge clk);
    model_edge(r, c, rs);
    #1;
    chk({tag, ".present"}, int'(present), int'(m_lvl));
    chk({tag, ".car_cnt"}, int'(car_cnt), m_cnt);
    chk({tag, ".x"}, int'(x), int'(m_cnt != 0));
  endtask

  // One complete car: on the loop long enough to be accepted, then gone long enough to release.
  task automatic one_car(input logic [1:0] c, input string tag);
    for (int i = 0; i < 7; i++) step(1'b1, c, 1'b0, tag);
    for (int i = 0; i < 7; i++) step(1'b0, c, 1'b0, tag);
  endtask

  initial begin
    logic r;
    logic [1:0] c;
    m_s1 = 0; m_s2 = 0; m_lvl = 0; m_run = 0; m_cnt = 0;

    // Reset, then a clean arrival with exact latency
    step(1'b0, LAMP_RED, 1'b1, "rst");
    step(1'b0, LAMP_RED, 1'b1, "rst");
    chk("rst_present", int'(present), 0);
    chk("rst_cnt", int'(car_cnt), 0);
    chk("rst_x", int'(x), 0);
    for (int e = 1; e <= 5; e++) begin
      step(1'b1, LAMP_RED, 1'b0, "arrive");
      chk("arrive_early_present", int'(present), 0);
      chk("arrive_early_x", int'(x), 0);
    end
    step(1'b1, LAMP_RED, 1'b0, "arrive");
    chk("arrive_edge6_present", int'(present), 1);
    chk("arrive_edge6_cnt", int'(car_cnt), 1);
    chk("arrive_edge6_x", int'(x), 1);

    // Bounce on release: two low cycles then high again keeps the same car
    step(1'b0, LAMP_RED, 1'b0, "bounce");
    step(1'b0, LAMP_RED, 1'b0, "bounce");
    for (int i = 0; i < 6; i++) step(1'b1, LAMP_RED, 1'b0, "bounce");
    chk("bounce_present", int'(present), 1);
    chk("bounce_cnt", int'(car_cnt), 1);
    for (int i = 0; i < 7; i++) step(1'b0, LAMP_RED, 1'b0, "release");
    chk("release_present", int'(present), 0);

    // Glitch of three samples is rejected
    step(1'b0, LAMP_GREEN, 1'b0, "clr");
    for (int i = 0; i < 3; i++) step(1'b1, LAMP_RED, 1'b0, "glitch");
    for (int i = 0; i < 8; i++) step(1'b0, LAMP_RED, 1'b0, "glitch");
    chk("glitch_present", int'(present), 0);
    chk("glitch_cnt", int'(car_cnt), 0);

    // Service: three waiting cars cleared by one GREEN cycle
    for (int k = 0; k < 3; k++) one_car(LAMP_YELLOW, "queue");
    chk("queue_cnt3", int'(car_cnt), 3);
    step(1'b0, LAMP_GREEN, 1'b0, "serve");
    chk("serve_cnt", int'(car_cnt), 0);
    chk("serve_x", int'(x), 0);
    for (int i = 0; i < 5; i++) step(1'b0, LAMP_RED, 1'b0, "serve_idle");
    chk("serve_idle_x", int'(x), 0);

    // Saturation, then a collision of arrival with GREEN
    for (int k = 0; k < 17; k++) one_car(LAMP_RED, "sat");
    chk("sat_cnt", int'(car_cnt), CMAX);
    for (int i = 0; i < 5; i++) step(1'b1, LAMP_RED, 1'b0, "coll");
    step(1'b1, LAMP_GREEN, 1'b0, "coll");
    chk("coll_present", int'(present), 1);
    chk("coll_cnt", int'(car_cnt), 0);
    chk("coll_x", int'(x), 0);
    for (int i = 0; i < 7; i++) step(1'b0, 2'd3, 1'b0, "unused_code");

    // Reset mid-debounce, then a fresh arrival needs the full latency again
    one_car(LAMP_RED, "pre_rst");
    for (int i = 0; i < 4; i++) step(1'b1, LAMP_RED, 1'b0, "arming");
    step(1'b1, LAMP_RED, 1'b1, "midrst");
    chk("midrst_cnt", int'(car_cnt), 0);
    chk("midrst_x", int'(x), 0);
    for (int i = 0; i < 5; i++) step(1'b1, LAMP_RED, 1'b0, "rearm");
    chk("rearm_early_present", int'(present), 0);
    step(1'b1, LAMP_RED, 1'b0, "rearm");
    chk("rearm_edge6_present", int'(present), 1);
    chk("rearm_edge6_cnt", int'(car_cnt), 1);

    // Randomized traffic against the model
    r = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0) r = ~r;
      c = ($urandom_range(0, 15) == 0) ? LAMP_GREEN : 2'($urandom_range(0, 3) == 2 ? 3 : $urandom_range(0, 1));
      step(r, c, ($urandom_range(0, 299) == 0), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
